// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving one external 1-bit cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_ctrl,
  output logic             cell_ci,
  input  logic             cell_s,
  input  logic             cell_co
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             mode;
  } op_t;

  logic [1:0]       state_q, state_d;
  op_t              op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic run;
  assign run = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    res_sh_d = res_sh_q;
    s_d      = s_q;
    co_d     = co_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d.a_sh = a;
          op_d.b_sh = b;
          op_d.mode = ctrl;
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          carry_d   = ctrl;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        res_sh_d  = {cell_s, res_sh_q[WIDTH-1:1]};
        carry_d   = cell_co;
        op_d.a_sh = op_q.a_sh >> 1;
        op_d.b_sh = op_q.b_sh >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = res_sh_d;
          co_d    = cell_co;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ cell_co;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_sh_q <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_sh_q <= res_sh_d;
      s_q      <= s_d;
      co_q     <= co_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif
  assign cell_a    = run & op_q.a_sh[0];
  assign cell_b    = run & op_q.b_sh[0];
  assign cell_ctrl = run & op_q.mode;
  assign cell_ci   = run & carry_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl with a behavioural 1-bit cell attached.
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ctrl = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, co;
  logic [W-1:0] s;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf;
`endif
  logic cell_a, cell_b, cell_ctrl, cell_ci, cell_s, cell_co, bx;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .co(co),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf(ovf),
`endif
    .cell_a(cell_a), .cell_b(cell_b), .cell_ctrl(cell_ctrl), .cell_ci(cell_ci),
    .cell_s(cell_s), .cell_co(cell_co)
  );

  // Full adder on A and (B xor Ctrl).
  assign bx      = cell_b ^ cell_ctrl;
  assign cell_s  = cell_a ^ bx ^ cell_ci;
  assign cell_co = (cell_a & bx) | (cell_a & cell_ci) | (bx & cell_ci);

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int unsigned cyc = 0;
  int   m_rem = 0;
  logic [W-1:0] last_s = '0;
  logic last_co = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic rc, input int unsigned c);
    exp_t e;
    int unsigned full, sa, sb_, ss;
    full = rc ? (int'(ra) + (1 << W) - int'(rb)) : (int'(ra) + int'(rb));
    e.cyc = c;
    e.s   = W'(full % (1 << W));
    e.co  = (full >= (1 << W));
    sa  = int'(ra[W-1]);
    sb_ = int'(rb[W-1]);
    ss  = int'(e.s[W-1]);
    e.ovf = rc ? ((sa != sb_) && (ss != sa)) : ((sa == sb_) && (ss != sa));
    return e;
  endfunction

  // Reference model: accepts start only when idle, busy for W+1 cycles afterwards.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0;
      sb.delete();
    end else begin
      cyc++;
      if (m_rem == 0) begin
        if (start) begin
          sb.push_back(ref_op(a, b, ctrl, cyc));
          m_rem = W + 1;
        end
      end else begin
        m_rem--;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_s  = '0;
      last_co = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("done", 32'(done), 32'(m_rem == 1));
      if (m_rem < 2)
        chk("cell_idle", 32'({cell_a, cell_b, cell_ctrl, cell_ci}), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 expected no pending op");
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.cyc, 32'(W));
          chk("s", 32'(s), 32'(e.s));
          chk("co", 32'(co), 32'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
          last_s  = e.s;
          last_co = e.co;
        end
      end else begin
        chk("s_hold", 32'(s), 32'(last_s));
        chk("co_hold", 32'(co), 32'(last_co));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    @(negedge clk);
    a = oa; b = ob; ctrl = oc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk(nm, 32'({busy, done, co, cell_a, cell_b, cell_ctrl, cell_ci}), 32'd0);
    chk({nm, "_s"}, 32'(s), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op(8'h3C, 8'h05, 1'b0);
    chk("add_s", 32'(s), 32'h41);
    do_op(8'h05, 8'h07, 1'b1);
    chk("sub_borrow_s", 32'(s), 32'hFE);
    chk("sub_borrow_co", 32'(co), 32'd0);
    do_op(8'h07, 8'h05, 1'b1);
    chk("sub_noborrow_co", 32'(co), 32'd1);
    do_op(8'hFF, 8'h01, 1'b0);
    chk("wrap_s", 32'(s), 32'h00);
    do_op(8'h7F, 8'h01, 1'b0);
    chk("ovf_s", 32'(s), 32'h80);
    do_op(8'h80, 8'h01, 1'b1);

    // start re-raised mid-run must be ignored
    @(negedge clk);
    a = 8'h11; b = 8'h22; ctrl = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; ctrl = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("ignore_s", 32'(s), 32'h33);
    do_op(8'h01, 8'h02, 1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    a = 8'h5A; b = 8'h33; ctrl = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midrun_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(8'h10, 8'h20, 1'b0);
    chk("post_reset_s", 32'(s), 32'h30);

    // start held high: model accepts one op every W+2 cycles
    @(negedge clk);
    start = 1'b1;
    repeat (45) begin
      a = W'($urandom); b = W'($urandom); ctrl = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    repeat (30) do_op(W'($urandom), W'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
